// File: rtl/nr_divider.sv
// nr_divider: multi-cycle non-restoring divider, one quotient bit per clock, start/done/busy handshake.
// Optional signed mode: define DIV_SIGNED_EN for two's-complement truncating division.
module nr_divider #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state;
    logic [WIDTH:0]   a, m, a_sh, a_nx, a_fix;
    logic [WIDTH-1:0] q, ld_q, ld_m, res_q, res_r;
    logic [CNT_W-1:0] cnt;
    always_comb begin
        a_sh  = {a[WIDTH-1:0], q[WIDTH-1]};
        a_nx  = a[WIDTH] ? a_sh + m : a_sh - m;
        a_fix = a[WIDTH] ? a + m : a;
    end
`ifdef DIV_SIGNED_EN
    logic sq, sr;
    always_comb begin
        ld_q  = dividend[WIDTH-1] ? -dividend : dividend;
        ld_m  = divisor[WIDTH-1] ? -divisor : divisor;
        res_q = sq ? -q : q;
        res_r = sr ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sq <= 1'b0;
            sr <= 1'b0;
        end else if (state == IDLE && start) begin
            sq <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sr <= dividend[WIDTH-1];
        end
    end
`else
    always_comb begin
        ld_q  = dividend;
        ld_m  = divisor;
        res_q = q;
        res_r = a_fix[WIDTH-1:0];
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a         <= '0;
            q         <= '0;
            m         <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && divisor == '0) begin
                        quotient  <= '1;
                        remainder <= dividend;
                        div_zero  <= 1'b1;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (start) begin
                        a     <= '0;
                        q     <= ld_q;
                        m     <= {1'b0, ld_m};
                        cnt   <= CNT_W'(WIDTH);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a     <= a_nx;
                    q     <= {q[WIDTH-2:0], ~a_nx[WIDTH]};
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == CNT_W'(1)) ? FIX : RUN;
                end
                FIX: begin
                    a         <= a_fix;
                    quotient  <= res_q;
                    remainder <= res_r;
                    div_zero  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nr_divider.sv
// tb_nr_divider: directed-vector self-checking bench for nr_divider.
module tb_nr_divider;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] dividend, divisor, quotient, remainder;
    logic       busy, done, div_zero;
    int         checks = 0, errors = 0;

    nr_divider #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                      input logic [7:0] eq, input logic [7:0] er, input logic edz,
                      input int elat, input int ebusy);
        int n = 0, b;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        b = int'(busy);
        while (!done && n < 40) begin
            @(posedge clk);
            #1 n++;
            if (busy) b++;
        end
        check({tag, " latency"}, n, elat);
        check({tag, " busy cycles"}, b, ebusy);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_zero"}, div_zero, edz);
        @(posedge clk);
        #1 check({tag, " done pulse"}, done, 0);
        check({tag, " quotient held"}, quotient, eq);
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        start = 1'b0;
        dividend = 8'd0;
        divisor = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset outputs", {quotient, remainder, 5'b0, busy, done, div_zero}, 0);

`ifdef DIV_SIGNED_EN
        op("s -7/2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 9, 9);
        op("s 7/-2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 9, 9);
        op("s -128/-1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 9, 9);
        op("s 5/0", 8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 0, 0);
        op("s 100/7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 9, 9);
`else
        op("100/7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 9, 9);
        op("255/1", 8'd255, 8'd1, 8'hFF, 8'h00, 1'b0, 9, 9);
        op("3/200", 8'd3, 8'd200, 8'h00, 8'h03, 1'b0, 9, 9);
        op("5/0", 8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 0, 0);
        op("9/3", 8'd9, 8'd3, 8'h03, 8'h00, 1'b0, 9, 9);
        op("255/16", 8'd255, 8'd16, 8'h0F, 8'h0F, 1'b0, 9, 9);

        // a second start while busy must be dropped without queuing
        @(negedge clk);
        dividend = 8'd50;
        divisor = 8'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend = 8'd9;
        divisor = 8'd9;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        check("ignore quotient", quotient, 8'h0A);
        check("ignore remainder", remainder, 8'h00);
        check("ignore done count", dones, 1);

        @(negedge clk);
        dividend = 8'd200;
        divisor = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort outputs", {quotient, remainder, 5'b0, busy, done, div_zero}, 0);
        dones = 0;
        repeat (15) begin
            @(posedge clk);
            #1 if (done || busy) dones++;
        end
        check("abort no activity", dones, 0);
        op("200/3", 8'd200, 8'd3, 8'h42, 8'h02, 1'b0, 9, 9);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
